maxpool2x2: RTL and testbench
=============================

MAXPOOL2X2 -- requirements
Module: maxpool2x2

Interface
REQ-001 The block SHALL have parameter N, default 16: word width per channel, two's-complement fixed point.
REQ-002 The block SHALL have parameter CHANNEL, default 3: channels carried in parallel per pixel.
REQ-003 The block SHALL have parameter INPUT_SIZE, default 6: square input feature-map side; must be even and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port ce, input, 1 bit: global clock enable; while low, all registers hold.
REQ-007 The block SHALL have port input_vld, input, 1 bit: input_din carries one valid pixel this cycle.
REQ-008 The block SHALL have port input_din, input, CHANNEL*N bits: one pixel, channel c in bits [c*N +: N].
REQ-009 The block SHALL have port pool_dout, output, CHANNEL*N bits: one pooled pixel, same channel packing.
REQ-010 The block SHALL have port pool_dout_vld, output, 1 bit: pool_dout is valid this cycle.
REQ-011 The block SHALL have port pool_dout_end, output, 1 bit: pool_dout is the last pooled pixel of the frame.

Function
REQ-012 The block SHALL accept a pixel only in a cycle where ce=1 and input_vld=1; pixels arrive in row-major raster order, and idle gaps of any length between pixels are legal.
REQ-013 The block SHALL track position with col and row counters in 0..INPUT_SIZE-1; col increments per accepted pixel and wraps to 0 at INPUT_SIZE-1, which increments row.
REQ-014 After the pixel at (INPUT_SIZE-1, INPUT_SIZE-1), both counters SHALL return to 0 so the next frame follows with no dead cycle.
REQ-015 On an even row and even col, the block SHALL hold the pixel in a per-channel register h.
REQ-016 On an even row and odd col, the block SHALL write max(h, pixel) per channel into line-buffer entry col/2; the line buffer has depth INPUT_SIZE/2.
REQ-017 On an odd row and even col, the block SHALL load h with the pixel.
REQ-018 On an odd row and odd col, the block SHALL register pool_dout = max(linebuf[col/2], h, pixel) per channel.
REQ-019 In the same odd-row, odd-col case, the block SHALL assert pool_dout_vld on the next ce-enabled edge.
REQ-020 The max operation SHALL be a signed N-bit compare; on a tie either operand may be selected, since the values are equal. There is no width growth and no saturation.
REQ-021 Latency SHALL be one ce-enabled cycle from acceptance of the bottom-right pixel of a 2x2 window to pool_dout_vld.
REQ-022 The block SHALL produce (INPUT_SIZE/2)^2 outputs per frame.
REQ-023 pool_dout_vld SHALL be a one-cycle pulse; it deasserts on the next ce-enabled edge with no qualifying input.
REQ-024 pool_dout_end SHALL be asserted together with pool_dout_vld only for the window containing pixel (INPUT_SIZE-1, INPUT_SIZE-1).
REQ-025 pool_dout SHALL hold its last value while pool_dout_vld=0.
REQ-026 While ce=0, the block SHALL keep all counters, h, the line buffer and all outputs, including vld and end, unchanged; input_vld is ignored.
REQ-027 A simultaneous last input pixel and first pixel of the next frame is impossible, because input is one pixel per cycle; the next frame's pixel in the following cycle SHALL be accepted normally.

Reset
REQ-028 On rst_n=0, the block SHALL immediately clear pool_dout, pool_dout_vld, pool_dout_end, col, row and h to 0, regardless of clk.
REQ-029 On rst_n=0, line-buffer contents SHALL be don't-care, because they are always written before being read.
REQ-030 Reset in mid-frame SHALL abandon the partial frame; the first pixel accepted after release is treated as (0,0).

Structure
REQ-031 A shared package SHALL hold the default N, a signed-max function, and the CHANNEL*N slicing helpers; the dconv and pconv stages use these too.
REQ-032 The block SHALL use one sub-module, smax2: a combinational per-channel signed max of two N-bit values, instantiated as needed per channel.
REQ-033 The line buffer SHALL be a register array of INPUT_SIZE/2 x CHANNEL*N; no RAM macro is used.
REQ-034 The block SHALL connect directly downstream of dwconv_c1, taking conv_dout, conv_dout_vld and ce unchanged.

Verification
REQ-035 Bench SHALL drive an 8x8 map, CHANNEL=1, pixel = row*8+col, with input_vld continuous -> 16 outputs 9,11,13,15,25,...,63; pool_dout_end only on 63.
REQ-036 Bench SHALL drive a signed map with all values negative and max -1 at (1,1) -> output 0 is 0xFFFF, not a positive wrap.
REQ-037 Bench SHALL insert random input_vld gaps and ce=0 stretches of 1-5 cycles -> the output sequence is identical to REQ-035, and no vld fires while ce=0.
REQ-038 Bench SHALL send two back-to-back frames -> 32 outputs, pool_dout_end pulses exactly twice, and the second frame's results are not contaminated by the first.
REQ-039 Bench SHALL assert rst_n=0 after 20 pixels of frame 1, then send a full frame -> outputs are all 0 during reset, and exactly 16 correct outputs follow.
REQ-040 Bench SHALL use CHANNEL=3 with channel 1 = -(channel 0) and channel 2 constant 0x7FFF -> each channel is pooled independently; channel 2 outputs are all 0x7FFF.

Source files
------------

// File: rtl/maxpool2x2_pkg.sv
// Shared definitions for the CNN pipeline stages (maxpool, dconv, pconv):
// default word width, a signed-max helper, per-channel slicing helpers and
// the 2x2 window phase encoding used by the pooling stage.
package maxpool2x2_pkg;

  localparam int unsigned DEFAULT_N = 16;

  // Position of a pixel inside its 2x2 window, encoded as {row[0], col[0]}
  typedef enum logic [1:0] {
    PH_TOP_LEFT  = 2'b00,
    PH_TOP_RIGHT = 2'b01,
    PH_BOT_LEFT  = 2'b10,
    PH_BOT_RIGHT = 2'b11
  } win_phase_e;

  // Signed max of two default-width words
  function automatic logic [DEFAULT_N-1:0] smax(input logic [DEFAULT_N-1:0] a,
                                               input logic [DEFAULT_N-1:0] b);
    return ($signed(a) >= $signed(b)) ? a : b;
  endfunction

  // LSB of channel ch in a CHANNEL*n packed pixel
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned n);
    return ch * n;
  endfunction

  // MSB of channel ch in a CHANNEL*n packed pixel
  function automatic int unsigned chan_msb(input int unsigned ch, input int unsigned n);
    return (ch * n) + n - 1;
  endfunction

endpackage

// File: rtl/maxpool2x2_smax2.sv
// Combinational signed max of two N-bit two's-complement words.
// Ports: a, b - operands; y_c - the larger operand (either one on a tie).
module smax2 #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y_c
);

  assign y_c = ($signed(a) >= $signed(b)) ? a : b;

endmodule

// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max pooling over a raster-ordered square feature map.
// Top-row pairs are reduced into a half-width line buffer; the bottom row
// combines them with its own pair and emits one pooled pixel per window.
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   ce              - global clock enable, everything holds while low
//   input_vld/_din  - one pixel per accepted cycle, channel c at [c*N +: N]
//   pool_dout       - pooled pixel, same channel packing, held between pulses
//   pool_dout_vld   - one-cycle (ce-qualified) pulse per pooled pixel
//   pool_dout_end   - marks the last pooled pixel of the frame
module maxpool2x2
  import maxpool2x2_pkg::*;
#(
  parameter int unsigned N          = DEFAULT_N,
  parameter int unsigned CHANNEL    = 3,
  parameter int unsigned INPUT_SIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 input_vld,
  input  logic [CHANNEL*N-1:0] input_din,
  output logic [CHANNEL*N-1:0] pool_dout,
  output logic                 pool_dout_vld,
  output logic                 pool_dout_end
);

  localparam int unsigned W    = CHANNEL * N;
  localparam int unsigned HALF = INPUT_SIZE / 2;
  localparam int unsigned CW   = (INPUT_SIZE > 2) ? $clog2(INPUT_SIZE) : 1;
  localparam int unsigned LW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned LAST = INPUT_SIZE - 1;

  logic [CW-1:0] col_q;
  logic [CW-1:0] row_q;
  logic [W-1:0]  h_q;
  logic [W-1:0]  linebuf_q [HALF];

  logic          accept;
  logic          col_last;
  logic          row_last;
  win_phase_e    phase;
  logic [LW-1:0] lb_idx;
  logic [W-1:0]  lb_rd;
  logic [W-1:0]  max_hp;
  logic [W-1:0]  max_all;

  assign accept   = ce & input_vld;
  assign col_last = (col_q == CW'(LAST));
  assign row_last = (row_q == CW'(LAST));
  assign phase    = win_phase_e'({row_q[0], col_q[0]});
  assign lb_idx   = LW'(col_q >> 1);
  assign lb_rd    = linebuf_q[lb_idx];

  // Per-channel max(h, pixel), then max with the buffered top-row pair
  for (genvar c = 0; c < CHANNEL; c++) begin : gen_chan
    smax2 #(.N(N)) u_max_hp (
      .a   (h_q[chan_lsb(c, N) +: N]),
      .b   (input_din[chan_lsb(c, N) +: N]),
      .y_c (max_hp[chan_lsb(c, N) +: N])
    );
    smax2 #(.N(N)) u_max_all (
      .a   (lb_rd[chan_lsb(c, N) +: N]),
      .b   (max_hp[chan_lsb(c, N) +: N]),
      .y_c (max_all[chan_lsb(c, N) +: N])
    );
  end

  // Position counters, left-pixel hold register and pooled output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q         <= '0;
      row_q         <= '0;
      h_q           <= '0;
      pool_dout     <= '0;
      pool_dout_vld <= 1'b0;
      pool_dout_end <= 1'b0;
    end else if (ce) begin
      pool_dout_vld <= 1'b0;
      pool_dout_end <= 1'b0;
      if (input_vld) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        case (phase)
          PH_TOP_LEFT,
          PH_BOT_LEFT:  h_q <= input_din;
          PH_BOT_RIGHT: begin
            pool_dout     <= max_all;
            pool_dout_vld <= 1'b1;
            pool_dout_end <= col_last & row_last;
          end
          default: ;
        endcase
      end
    end
  end

  // Line buffer: always written on the top row before the bottom row reads it
  always_ff @(posedge clk) begin
    if (accept && (phase == PH_TOP_RIGHT)) begin
      linebuf_q[lb_idx] <= max_hp;
    end
  end

endmodule

// File: tb/tb_maxpool2x2.sv
// Directed bench for maxpool2x2: 8x8 maps, three channels, 16-bit words.
module tb_maxpool2x2;

  localparam int unsigned N    = 16;
  localparam int unsigned CH   = 3;
  localparam int unsigned SZ   = 8;
  localparam int unsigned W    = CH * N;
  localparam int unsigned HALF = SZ / 2;
  localparam int unsigned NOUT = HALF * HALF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ce;
  logic         input_vld;
  logic [W-1:0] input_din;
  logic [W-1:0] pool_dout;
  logic         pool_dout_vld;
  logic         pool_dout_end;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q_d[$];
  logic         q_e[$];
  int           ce_low_changes = 0;
  logic         ce_prev = 1'b1;
  logic         vld_prev;
  logic         end_prev;
  logic [W-1:0] dout_prev;

  maxpool2x2 #(.N(N), .CHANNEL(CH), .INPUT_SIZE(SZ)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ce            (ce),
    .input_vld     (input_vld),
    .input_din     (input_din),
    .pool_dout     (pool_dout),
    .pool_dout_vld (pool_dout_vld),
    .pool_dout_end (pool_dout_end)
  );

  always #5 clk = ~clk;

  // Record each pooled pixel once (when consumed on a ce-enabled edge) and
  // flag any output change across an edge where ce was low.
  always @(negedge clk) begin
    if (!ce_prev && (pool_dout_vld !== vld_prev || pool_dout_end !== end_prev ||
                     pool_dout !== dout_prev))
      ce_low_changes <= ce_low_changes + 1;
    if (ce && pool_dout_vld) begin
      q_d.push_back(pool_dout);
      q_e.push_back(pool_dout_end);
    end
    ce_prev   <= ce;
    vld_prev  <= pool_dout_vld;
    end_prev  <= pool_dout_end;
    dout_prev <= pool_dout;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel generators: 0 = ramp, 1 = all-negative with -1 at (1,1), 2 = descending
  function automatic logic [W-1:0] pix(input int kind, input int r, input int c);
    logic [N-1:0] v;
    case (kind)
      0: begin
        v = N'(r * SZ + c);
        return {16'h7FFF, N'(0) - v, v};
      end
      1: begin
        v = (r == 1 && c == 1) ? 16'hFFFF : N'(-100 - (r * SZ + c));
        return {v, v, v};
      end
      default: begin
        v = N'(200 - (r * SZ + c));
        return {16'h7FFF, N'(0) - v, v};
      end
    endcase
  endfunction

  // Expected pooled pixel for window (i,j): signed max over the four pixels
  function automatic logic [W-1:0] model(input int kind, input int i, input int j);
    logic [W-1:0]        res;
    logic [W-1:0]        p;
    logic signed [N-1:0] m;
    logic signed [N-1:0] x;
    res = '0;
    for (int ch = 0; ch < int'(CH); ch++) begin
      p = pix(kind, 2 * i, 2 * j);
      m = p[ch * N +: N];
      for (int k = 1; k < 4; k++) begin
        p = pix(kind, 2 * i + k / 2, 2 * j + k % 2);
        x = p[ch * N +: N];
        if (x > m) m = x;
      end
      res[ch * N +: N] = m;
    end
    return res;
  endfunction

  function automatic logic [W-1:0] qd(input int idx);
    return (idx < q_d.size()) ? q_d[idx] : 'x;
  endfunction

  function automatic logic qe(input int idx);
    return (idx < q_e.size()) ? q_e[idx] : 1'bx;
  endfunction

  function automatic int count_ends();
    int n = 0;
    foreach (q_e[k]) if (q_e[k]) n++;
    return n;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send npix pixels in raster order; optionally insert vld gaps / ce-low stretches
  task automatic send_frame(input int kind, input int npix, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      if (gaps) begin
        int mode;
        int len;
        mode = int'($urandom_range(0, 2));
        len  = int'($urandom_range(1, 5));
        if (mode == 1) begin
          ce = 1'b1;
          input_vld = 1'b0;
          idle(len);
        end else if (mode == 2) begin
          ce = 1'b0;
          input_vld = 1'b1;
          input_din = W'({$urandom, $urandom});
          idle(len);
        end
      end
      ce = 1'b1;
      input_vld = 1'b1;
      input_din = pix(kind, p / int'(SZ), p % int'(SZ));
      @(posedge clk);
      #1;
    end
    input_vld = 1'b0;
  endtask

  task automatic check_frame(input int kind, input int base, input string tag);
    int idx;
    for (int i = 0; i < int'(HALF); i++) begin
      for (int j = 0; j < int'(HALF); j++) begin
        idx = base + i * int'(HALF) + j;
        check($sformatf("%s_dout[%0d]", tag, idx), qd(idx), model(kind, i, j));
        check($sformatf("%s_end[%0d]", tag, idx), W'(qe(idx)),
              W'(i == int'(HALF) - 1 && j == int'(HALF) - 1));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ce        = 1'b1;
    input_vld = 1'b0;
    input_din = '0;
    #12;
    check("reset_dout", pool_dout, '0);
    check("reset_vld", W'(pool_dout_vld), '0);
    check("reset_end", W'(pool_dout_end), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Continuous ramp frame, then ce-low hold and post-pulse hold
    send_frame(0, 64, 1'b0);
    check("t1_last_vld", W'(pool_dout_vld), W'(1'b1));
    check("t1_last_end", W'(pool_dout_end), W'(1'b1));
    ce = 1'b0;
    idle(3);
    check("t1_celow_vld", W'(pool_dout_vld), W'(1'b1));
    check("t1_celow_end", W'(pool_dout_end), W'(1'b1));
    check("t1_celow_dout", pool_dout, 48'h7FFF_FFCA_003F);
    ce = 1'b1;
    idle(1);
    check("t1_pulse_vld", W'(pool_dout_vld), '0);
    check("t1_pulse_end", W'(pool_dout_end), '0);
    check("t1_hold_dout", pool_dout, 48'h7FFF_FFCA_003F);
    idle(3);
    check("t1_count", W'(q_d.size()), W'(NOUT));
    check("t1_ends", W'(count_ends()), W'(1));
    check("t1_first", qd(0), 48'h7FFF_0000_0009);
    check("t1_second", qd(1), 48'h7FFF_FFFE_000B);
    check("t1_fifth", qd(4), 48'h7FFF_FFF0_0019);
    check("t1_last", qd(15), 48'h7FFF_FFCA_003F);
    check_frame(0, 0, "t1");
    q_d.delete();
    q_e.delete();

    // All-negative frame: -1 must win window 0, no positive wrap
    send_frame(1, 64, 1'b0);
    idle(4);
    check("t2_count", W'(q_d.size()), W'(NOUT));
    check("t2_first", qd(0), 48'hFFFF_FFFF_FFFF);
    check("t2_second", qd(1), 48'hFF9A_FF9A_FF9A);
    check_frame(1, 0, "t2");
    q_d.delete();
    q_e.delete();

    // Ramp frame with random vld gaps and ce-low stretches
    send_frame(0, 64, 1'b1);
    idle(4);
    check("t3_count", W'(q_d.size()), W'(NOUT));
    check("t3_last", qd(15), 48'h7FFF_FFCA_003F);
    check_frame(0, 0, "t3");
    q_d.delete();
    q_e.delete();

    // Two back-to-back frames with different content
    send_frame(0, 64, 1'b0);
    send_frame(2, 64, 1'b0);
    idle(4);
    check("t4_count", W'(q_d.size()), W'(2 * NOUT));
    check("t4_ends", W'(count_ends()), W'(2));
    check("t4_f2_first", qd(16), 48'h7FFF_FF41_00C8);
    check_frame(0, 0, "t4a");
    check_frame(2, 16, "t4b");
    q_d.delete();
    q_e.delete();

    // Reset mid-frame after 20 pixels, then a full clean frame
    send_frame(0, 20, 1'b0);
    check("t5_pre_vld", W'(pool_dout_vld), '0);
    check("t5_pre_dout", pool_dout, 48'h7FFF_FFFA_000F);
    rst_n = 1'b0;
    #1;
    check("t5_rst_dout", pool_dout, '0);
    check("t5_rst_vld", W'(pool_dout_vld), '0);
    check("t5_rst_end", W'(pool_dout_end), '0);
    idle(2);
    check("t5_rst_hold_dout", pool_dout, '0);
    rst_n = 1'b1;
    q_d.delete();
    q_e.delete();
    idle(1);
    send_frame(0, 64, 1'b0);
    idle(4);
    check("t5_count", W'(q_d.size()), W'(NOUT));
    check("t5_ends", W'(count_ends()), W'(1));
    check_frame(0, 0, "t5");

    check("ce_low_output_changes", W'(ce_low_changes), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
